// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous square wave in clk cycles.
// Defining PERIOD_METER_TIMEOUT_EN adds an idle timeout that returns the FSM to ARM.
module period_meter #(
  parameter int          WIDTH       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_sig_in,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high_time,
  output logic             o_valid,
  output logic             o_ovf,
  output logic             o_timeout
);

  // IDLE | disabled, counters cleared ; ARM | waiting for first rise ; MEAS | counting a period
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("period_meter: SYNC_STAGES must be at least 2");
  end
  if ((64'(TIMEOUT_CYC) < 64'd2) || (64'(TIMEOUT_CYC) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_to
    $error("period_meter: TIMEOUT_CYC out of range");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Edge detects are registered so the counter logic sees s, rise and fall aligned in one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
      r_fall <= ~w_s & r_s_d;
    end
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pcnt;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_hlat;
  logic             r_fall_seen;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_valid;
  logic             r_ovf;

  logic [WIDTH-1:0] w_pcnt_inc;
  logic [WIDTH-1:0] w_hcnt_inc;
  logic             w_meas_step;
  logic             w_ovf_set;
  logic             w_to_hit;

  assign w_pcnt_inc  = (r_pcnt == CNT_MAX) ? CNT_MAX : r_pcnt + CNT_ONE;
  assign w_hcnt_inc  = (r_hcnt == CNT_MAX) ? CNT_MAX : r_hcnt + CNT_ONE;
  assign w_meas_step = i_en && (r_state == ST_MEAS) && !r_rise;
  assign w_ovf_set   = w_meas_step && ((r_pcnt == CNT_PRE) || (r_s_d && (r_hcnt == CNT_PRE)));

`ifdef PERIOD_METER_TIMEOUT_EN
  localparam logic [WIDTH-1:0] TO_VAL = WIDTH'(TIMEOUT_CYC);
  logic r_timeout;

  assign w_to_hit  = w_meas_step && (w_pcnt_inc == TO_VAL);
  assign o_timeout = r_timeout;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_timeout & ~i_clr) | w_to_hit;
    end
  end
`else
  assign w_to_hit  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pcnt      <= '0;
      r_hcnt      <= '0;
      r_hlat      <= '0;
      r_fall_seen <= 1'b0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!i_en) begin
        r_state     <= ST_IDLE;
        r_pcnt      <= '0;
        r_hcnt      <= '0;
        r_hlat      <= '0;
        r_fall_seen <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_ARM;
          ST_ARM: begin
            if (r_rise) begin
              r_state     <= ST_MEAS;
              r_pcnt      <= CNT_ONE;
              r_hcnt      <= CNT_ONE;
              r_hlat      <= '0;
              r_fall_seen <= 1'b0;
            end
          end
          ST_MEAS: begin
            if (r_rise) begin
              // No fall since the last rise means the high phase saturated with the period.
              r_period    <= r_pcnt;
              r_high_time <= r_fall_seen ? r_hlat : r_pcnt;
              r_valid     <= 1'b1;
              r_pcnt      <= CNT_ONE;
              r_hcnt      <= CNT_ONE;
              r_hlat      <= '0;
              r_fall_seen <= 1'b0;
            end else if (w_to_hit) begin
              r_state     <= ST_ARM;
              r_pcnt      <= '0;
              r_hcnt      <= '0;
              r_hlat      <= '0;
              r_fall_seen <= 1'b0;
            end else begin
              r_pcnt <= w_pcnt_inc;
              if (r_s_d) begin
                r_hcnt <= w_hcnt_inc;
              end
              if (r_fall) begin
                r_hlat      <= r_hcnt;
                r_fall_seen <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Set wins over clear so a saturation coinciding with clr is not lost.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~i_clr) | w_ovf_set;
    end
  end

  assign o_period    = r_period;
  assign o_high_time = r_high_time;
  assign o_valid     = r_valid;
  assign o_ovf       = r_ovf;

endmodule
